// File: rtl/divisor_pkg.sv
// divisor_pkg: shared FSM state type and sizing constants for the sequential divider.
package divisor_pkg;
   localparam int MAX_WIDTH = 32;
   localparam int COUNT_W = $clog2(MAX_WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/subtrator_n.sv
// subtrator_n: N-bit subtractor returning the difference and the borrow-out.
module subtrator_n #(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow
);
   assign {borrow, diff} = {1'b0, a} - {1'b0, b};
endmodule

// File: rtl/divisor_sequencial.sv
// divisor_sequencial: restoring divider, one quotient bit per cycle, optional signed mode.
// Outputs are registered from the FSM state, so they trail it by one cycle.
module divisor_sequencial
   import divisor_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter bit SIGNED_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sgn,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             ERR,
   output logic             OVF
);
   state_t state_q, state_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, q_q, q_d, r_q, r_d;
   logic [WIDTH:0] p_q, p_d, shifted, diff;
   logic neg_q_q, neg_q_d, neg_r_q, neg_r_d, op_err_q, op_err_d, op_ovf_q, op_ovf_d;
   logic busy_q, busy_d, done_q, done_d, err_q, err_d, ovf_q, ovf_d;
   logic s, borrow, accept, bz;
   logic [WIDTH-1:0] a_mag, b_mag;
   assign s = SIGNED_EN && sgn;
   assign a_mag = (s && A[WIDTH-1]) ? -A : A;
   assign b_mag = (s && B[WIDTH-1]) ? -B : B;
   assign bz = (B == '0);
   assign accept = start && (state_q != RUN);
   assign shifted = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
   subtrator_n #(.N(WIDTH + 1)) u_sub (
      .a(shifted),
      .b({1'b0, b_q}),
      .diff(diff),
      .borrow(borrow)
   );
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      a_d = a_q;
      b_d = b_q;
      p_d = p_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      op_err_d = op_err_q;
      op_ovf_d = op_ovf_q;
      busy_d = (state_q == RUN);
      done_d = (state_q == DONE);
      q_d = q_q;
      r_d = r_q;
      err_d = err_q;
      ovf_d = ovf_q;
      if (state_q == RUN) begin
         p_d = borrow ? shifted : diff;
         a_d = {a_q[WIDTH-2:0], ~borrow};
         count_d = count_q - COUNT_W'(1);
         state_d = (count_q == COUNT_W'(1)) ? DONE : RUN;
      end
      if (state_q == DONE) begin
         q_d = neg_q_q ? -a_q : a_q;
         r_d = neg_r_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
         err_d = op_err_q;
         ovf_d = op_ovf_q;
         state_d = IDLE;
      end
      // divide-by-zero preloads the result registers so DONE formats it like any other result
      if (accept) begin
         state_d = bz ? DONE : RUN;
         count_d = bz ? '0 : COUNT_W'(WIDTH);
         a_d = bz ? '1 : a_mag;
         b_d = b_mag;
         p_d = bz ? {1'b0, A} : '0;
         neg_q_d = !bz && s && (A[WIDTH-1] ^ B[WIDTH-1]);
         neg_r_d = !bz && s && A[WIDTH-1];
         op_err_d = bz;
         op_ovf_d = s && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         a_q <= '0;
         b_q <= '0;
         p_q <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         op_err_q <= 1'b0;
         op_ovf_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         q_q <= '0;
         r_q <= '0;
         err_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         a_q <= a_d;
         b_q <= b_d;
         p_q <= p_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         op_err_q <= op_err_d;
         op_ovf_q <= op_ovf_d;
         busy_q <= busy_d;
         done_q <= done_d;
         q_q <= q_d;
         r_q <= r_d;
         err_q <= err_d;
         ovf_q <= ovf_d;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign Q = q_q;
   assign R = r_q;
   assign ERR = err_q;
   assign OVF = ovf_q;
endmodule

// File: tb/tb_divisor_sequencial.sv
// tb_divisor_sequencial: directed vector table plus busy, back-to-back and reset sequences.
module tb_divisor_sequencial;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, sgn = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic busy, done, err, ovf;
   logic [7:0] q, r;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   divisor_sequencial #(.WIDTH(8), .SIGNED_EN(1)) dut (
      .clk(clk), .rst(rst), .start(start), .sgn(sgn), .A(a), .B(b),
      .busy(busy), .done(done), .Q(q), .R(r), .ERR(err), .OVF(ovf)
   );
   typedef struct {
      logic [7:0] a, b;
      logic s;
      logic [7:0] eq, er;
      logic eerr, eovf;
      int elat;
   } vec_t;
   vec_t v[12];
   task automatic chk(input string n, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask
   task automatic go(input logic [7:0] ai, input logic [7:0] bi, input logic si);
      a = ai;
      b = bi;
      sgn = si;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask
   task automatic wait_done(output int lat, output int bn);
      lat = -1;
      bn = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (busy) bn++;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask
   initial begin
      int lat, bn, seen;
      v[0]  = '{8'd200, 8'd7,   1'b0, 8'd28,  8'd4,   1'b0, 1'b0, 9};
      v[1]  = '{8'd13,  8'd0,   1'b0, 8'hFF,  8'd13,  1'b1, 1'b0, 1};
      v[2]  = '{8'hF9,  8'd2,   1'b1, 8'hFD,  8'hFF,  1'b0, 1'b0, 9};
      v[3]  = '{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0, 1'b1, 9};
      v[4]  = '{8'h80,  8'hFF,  1'b0, 8'h00,  8'h80,  1'b0, 1'b0, 9};
      v[5]  = '{8'hFF,  8'hFF,  1'b0, 8'h01,  8'h00,  1'b0, 1'b0, 9};
      v[6]  = '{8'd255, 8'd16,  1'b0, 8'd15,  8'd15,  1'b0, 1'b0, 9};
      v[7]  = '{8'd7,   8'hF9,  1'b1, 8'hFF,  8'h00,  1'b0, 1'b0, 9};
      v[8]  = '{8'hF9,  8'hFE,  1'b1, 8'h03,  8'hFF,  1'b0, 1'b0, 9};
      v[9]  = '{8'd100, 8'hFD,  1'b1, 8'hDF,  8'h01,  1'b0, 1'b0, 9};
      v[10] = '{8'd5,   8'd9,   1'b0, 8'h00,  8'h05,  1'b0, 1'b0, 9};
      v[11] = '{8'hF9,  8'h00,  1'b1, 8'hFF,  8'hF9,  1'b1, 1'b0, 1};
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_q", q, 0);
      chk("reset_r", r, 0);
      chk("reset_err", err, 0);
      chk("reset_ovf", ovf, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      for (int i = 0; i < 12; i++) begin
         go(v[i].a, v[i].b, v[i].s);
         wait_done(lat, bn);
         chk($sformatf("v%0d_lat", i), lat, v[i].elat);
         chk($sformatf("v%0d_busy", i), bn, v[i].elat == 1 ? 0 : 8);
         chk($sformatf("v%0d_q", i), q, v[i].eq);
         chk($sformatf("v%0d_r", i), r, v[i].er);
         chk($sformatf("v%0d_err", i), err, v[i].eerr);
         chk($sformatf("v%0d_ovf", i), ovf, v[i].eovf);
         @(posedge clk);
         #1 chk($sformatf("v%0d_pulse", i), done, 0);
      end
      // start pulsed mid-run must be ignored
      go(8'd200, 8'd7, 1'b0);
      repeat (3) @(posedge clk);
      #1 begin a = 8'd9; b = 8'd3; start = 1'b1; end
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat, bn);
      chk("ign_lat", lat, 5);
      chk("ign_q", q, 28);
      chk("ign_r", r, 4);
      // start held through the done cycle starts the next division
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 chk("hold_busy", busy, 1);
      chk("hold_q", q, 28);
      chk("hold_r", r, 4);
      wait_done(lat, bn);
      chk("b2b_lat", lat, 5);
      chk("b2b_q", q, 3);
      chk("b2b_r", r, 0);
      @(posedge clk);
      // reset in the 4th run cycle abandons the division
      #1 go(8'd200, 8'd7, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         if (done) seen = 1;
         @(posedge clk);
         #1;
      end
      chk("rst_nodone", seen, 0);
      chk("rst_q", q, 0);
      chk("rst_r", r, 0);
      chk("rst_busy", busy, 0);
      go(8'd255, 8'd16, 1'b0);
      wait_done(lat, bn);
      chk("post_rst_lat", lat, 9);
      chk("post_rst_q", q, 15);
      chk("post_rst_r", r, 15);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
